alpha_engine: RTL and testbench

Parametrised forward state-metric (alpha) recursion for the max-log-MAP SISO decoder, the successor of the fixed 16-bit alpha unit. It sits between the branch-metric stage and the beta/LLR stage. It consumes one branch-metric pair per trellis step and emits the eight alpha metrics for that step. Compared with the fixed unit, it adds configurable metric width, per-frame block length, per-step normalisation with saturation, frame-last flagging and error reporting.

---
 rtl/siso_pkg.sv | 38 +++
 rtl/alpha_engine_acs.sv | 22 ++
 rtl/alpha_engine.sv | 163 ++++++++++++++++
 tb/tb_alpha_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared trellis definitions for the max-log-MAP SISO blocks.
// Covers the LTE RSC 8-state trellis, metric helpers and the recursion FSM states.
package siso_pkg;

   localparam int N_STATES         = 8;
   localparam int K_MIN_DEFAULT    = 40;
   localparam int K_MAX_DEFAULT    = 6144;

   typedef enum logic [0:0] {IDLE, RUN} fsm_t;

   // State bits: s[2]=s1, s[1]=s2, s[0]=s3
   function automatic logic [2:0] next_state(input logic [2:0] s, input logic u);
      logic a;
      a = u ^ s[1] ^ s[0];
      return {a, s[2], s[1]};
   endfunction

   function automatic logic parity(input logic [2:0] s, input logic u);
      logic a;
      a = u ^ s[1] ^ s[0];
      return a ^ s[2] ^ s[0];
   endfunction

   function automatic longint neg_inf(input int w);
      return -(longint'(1) << (w - 2));
   endfunction

   function automatic longint saturate(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/alpha_engine_acs.sv
// Add-compare-select for one destination state; purely combinational.
// Output is the raw (un-normalised) winner at METRIC_W+2 bits; ties keep the lower-index predecessor.
module acs_unit #(
   parameter int METRIC_W = 16
) (
   input  logic signed [METRIC_W-1:0] alpha_lo,
   input  logic signed [METRIC_W-1:0] alpha_hi,
   input  logic signed [METRIC_W+1:0] gamma_lo,
   input  logic signed [METRIC_W+1:0] gamma_hi,
   output logic signed [METRIC_W+1:0] raw
);

   logic signed [METRIC_W+1:0] sum_lo;
   logic signed [METRIC_W+1:0] sum_hi;

   always_comb begin
      sum_lo = (METRIC_W+2)'(alpha_lo) + gamma_lo;
      sum_hi = (METRIC_W+2)'(alpha_hi) + gamma_hi;
      raw    = (sum_lo >= sum_hi) ? sum_lo : sum_hi;
   end

endmodule

// File: rtl/alpha_engine.sv
// Forward alpha recursion, one trellis step per valid_branch; outputs registered 1 cycle after the step.
// No backpressure: every accepted branch produces valid_alpha; protocol violations pulse err.
module alpha_engine
   import siso_pkg::*;
#(
   parameter int METRIC_W = 16,
   parameter int BM_W     = 16,
   parameter int K_MIN    = K_MIN_DEFAULT,
   parameter int K_MAX    = K_MAX_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [15:0]                  blklen,
   input  logic                         valid_blklen,
   input  logic signed [BM_W-1:0]       init_branch1,
   input  logic signed [BM_W-1:0]       init_branch2,
   input  logic                         valid_branch,
   output logic [N_STATES*METRIC_W-1:0] alpha,
   output logic                         valid_alpha,
   output logic                         last_alpha,
   output logic                         busy,
   output logic                         err
);

   localparam int SW = METRIC_W + 2;
   localparam int VW = N_STATES * METRIC_W;
   localparam logic signed [METRIC_W-1:0] NINF = METRIC_W'(neg_inf(METRIC_W));

   function automatic logic [VW-1:0] init_vector();
      logic [VW-1:0] v;
      v = '0;
      for (int s = 1; s < N_STATES; s++) v[s*METRIC_W +: METRIC_W] = NINF;
      return v;
   endfunction

   localparam logic [VW-1:0] INIT_VEC = init_vector();

   fsm_t            state_q, state_d;
   logic [15:0]     klen_q, klen_d;
   logic [15:0]     k_q, k_d;
   logic [VW-1:0]   areg_q, areg_d;
   logic [VW-1:0]   alpha_q, alpha_d;
   logic            valid_alpha_q, valid_alpha_d;
   logic            last_alpha_q, last_alpha_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;

   logic signed [SW-1:0] g_pos1, g_pos2, g_neg1, g_neg2;
   logic signed [SW-1:0] raw [N_STATES];
   logic [VW-1:0]        norm;

   always_comb begin
      g_pos1 = SW'(init_branch1);
      g_pos2 = SW'(init_branch2);
      g_neg1 = -g_pos1;
      g_neg2 = -g_pos2;
   end

   // Destination d is reached from {d[1:0],0} and {d[1:0],1}; input bit and parity resolved at elaboration.
   for (genvar d = 0; d < N_STATES; d++) begin : g_acs
      localparam int   P_LO  = (d % 4) * 2;
      localparam int   P_HI  = P_LO + 1;
      localparam logic U_LO  = (next_state(3'(P_LO), 1'b1) == 3'(d));
      localparam logic U_HI  = (next_state(3'(P_HI), 1'b1) == 3'(d));
      localparam logic PR_LO = parity(3'(P_LO), U_LO);
      localparam logic PR_HI = parity(3'(P_HI), U_HI);

      logic signed [SW-1:0] gam_lo;
      logic signed [SW-1:0] gam_hi;

      assign gam_lo = U_LO ? (PR_LO ? g_pos1 : g_pos2) : (PR_LO ? g_neg2 : g_neg1);
      assign gam_hi = U_HI ? (PR_HI ? g_pos1 : g_pos2) : (PR_HI ? g_neg2 : g_neg1);

      acs_unit #(.METRIC_W(METRIC_W)) u_acs (
         .alpha_lo (areg_q[P_LO*METRIC_W +: METRIC_W]),
         .alpha_hi (areg_q[P_HI*METRIC_W +: METRIC_W]),
         .gamma_lo (gam_lo),
         .gamma_hi (gam_hi),
         .raw      (raw[d])
      );
   end

   // The difference of two raw sums always fits SW bits, so only the final clamp can overflow.
   always_comb begin
      norm = '0;
      for (int s = 0; s < N_STATES; s++)
         norm[s*METRIC_W +: METRIC_W] = METRIC_W'(saturate(longint'(raw[s] - raw[0]), METRIC_W));
   end

   always_comb begin
      state_d       = state_q;
      klen_d        = klen_q;
      k_d           = k_q;
      areg_d        = areg_q;
      alpha_d       = alpha_q;
      valid_alpha_d = 1'b0;
      last_alpha_d  = 1'b0;
      busy_d        = busy_q;
      err_d         = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_blklen) begin
               if (32'(blklen) >= K_MIN && 32'(blklen) <= K_MAX) begin
                  klen_d  = blklen;
                  k_d     = '0;
                  areg_d  = INIT_VEC;
                  state_d = RUN;
                  busy_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (valid_branch) err_d = 1'b1;
         end
         RUN: begin
            if (valid_blklen) err_d = 1'b1;
            if (valid_branch) begin
               alpha_d       = areg_q;
               valid_alpha_d = 1'b1;
               areg_d        = norm;
               k_d           = k_q + 16'd1;
               if (k_q == klen_q - 16'd1) begin
                  last_alpha_d = 1'b1;
                  state_d      = IDLE;
                  busy_d       = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         klen_q        <= '0;
         k_q           <= '0;
         areg_q        <= INIT_VEC;
         alpha_q       <= '0;
         valid_alpha_q <= 1'b0;
         last_alpha_q  <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         klen_q        <= klen_d;
         k_q           <= k_d;
         areg_q        <= areg_d;
         alpha_q       <= alpha_d;
         valid_alpha_q <= valid_alpha_d;
         last_alpha_q  <= last_alpha_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
      end
   end

   assign alpha       = alpha_q;
   assign valid_alpha = valid_alpha_q;
   assign last_alpha  = last_alpha_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule

// File: tb/tb_alpha_engine.sv
// Randomised bench for alpha_engine: a 16-bit instance for protocol/recursion and a 12-bit one for saturation.
module tb_alpha_engine;
   import siso_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0]        a_blklen;
   logic               a_vblk, a_vbr;
   logic signed [15:0] a_b1, a_b2;
   logic [127:0]       a_alpha;
   logic               a_valid, a_last, a_busy, a_err;

   logic [15:0]        b_blklen;
   logic               b_vblk, b_vbr;
   logic signed [11:0] b_b1, b_b2;
   logic [95:0]        b_alpha;
   logic               b_valid, b_last, b_busy, b_err;

   alpha_engine dut_a (
      .clk(clk), .rst(rst), .blklen(a_blklen), .valid_blklen(a_vblk),
      .init_branch1(a_b1), .init_branch2(a_b2), .valid_branch(a_vbr),
      .alpha(a_alpha), .valid_alpha(a_valid), .last_alpha(a_last), .busy(a_busy), .err(a_err)
   );

   alpha_engine #(.METRIC_W(12), .BM_W(12)) dut_b (
      .clk(clk), .rst(rst), .blklen(b_blklen), .valid_blklen(b_vblk),
      .init_branch1(b_b1), .init_branch2(b_b2), .valid_branch(b_vbr),
      .alpha(b_alpha), .valid_alpha(b_valid), .last_alpha(b_last), .busy(b_busy), .err(b_err)
   );

   int     n_chk = 0;
   int     n_bad = 0;
   longint ref_a [8];
   longint exp_out [8];
   int     ref_w;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint got_s(input int which, input int s);
      if (which == 0) return longint'($signed(a_alpha[s*16 +: 16]));
      return longint'($signed(b_alpha[s*12 +: 12]));
   endfunction

   // {valid, last, busy, err}
   function automatic logic [3:0] flags(input int which);
      if (which == 0) return {a_valid, a_last, a_busy, a_err};
      return {b_valid, b_last, b_busy, b_err};
   endfunction

   function automatic longint rnd_bm(input int w);
      return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w - 1));
   endfunction

   function automatic void ref_init(input int w);
      ref_w = w;
      for (int s = 0; s < 8; s++) ref_a[s] = (s == 0) ? 0 : -(longint'(1) << (w - 2));
   endfunction

   // Walk every (state, input) edge forward and keep the best arrival per destination.
   function automatic void ref_step(input longint b1, input longint b2);
      longint best [8];
      bit     have [8];
      longint hi, lo, v;
      for (int s = 0; s < 8; s++) have[s] = 1'b0;
      for (int s = 0; s < 8; s++) begin
         for (int u = 0; u < 2; u++) begin
            int s1, s2, s3, a, p, ns;
            longint g;
            s1 = (s >> 2) & 1; s2 = (s >> 1) & 1; s3 = s & 1;
            a  = u ^ s2 ^ s3;
            p  = a ^ s1 ^ s3;
            ns = 4 * a + 2 * s1 + s2;
            if (u == 1) g = (p == 1) ? b1 : b2;
            else        g = (p == 0) ? -b1 : -b2;
            if (!have[ns] || ref_a[s] + g > best[ns]) begin
               best[ns] = ref_a[s] + g;
               have[ns] = 1'b1;
            end
         end
      end
      hi = (longint'(1) << (ref_w - 1)) - 1;
      lo = -(longint'(1) << (ref_w - 1));
      for (int s = 0; s < 8; s++) begin
         v = best[s] - best[0];
         if (v > hi) v = hi;
         if (v < lo) v = lo;
         ref_a[s] = v;
      end
   endfunction

   task automatic send_len(input int which, input int kk);
      if (which == 0) begin a_blklen = 16'(kk); a_vblk = 1'b1; end
      else            begin b_blklen = 16'(kk); b_vblk = 1'b1; end
      step();
      a_vblk = 1'b0;
      b_vblk = 1'b0;
   endtask

   task automatic do_branch(input int which, input longint b1, input longint b2, input bit exp_last);
      logic [3:0] f;
      if (which == 0) begin a_b1 = 16'(b1); a_b2 = 16'(b2); a_vbr = 1'b1; end
      else            begin b_b1 = 12'(b1); b_b2 = 12'(b2); b_vbr = 1'b1; end
      step();
      a_vbr = 1'b0;
      b_vbr = 1'b0;
      f = flags(which);
      chk("valid_alpha", f[3], 1);
      chk("last_alpha", f[2], exp_last);
      chk("busy", f[1], !exp_last);
      chk("err_in_frame", f[0], 0);
      for (int s = 0; s < 8; s++) begin
         chk($sformatf("alpha_s%0d", s), got_s(which, s), ref_a[s]);
         exp_out[s] = ref_a[s];
      end
      ref_step(b1, b2);
   endtask

   task automatic idle_cycles(input int which, input int n);
      logic [3:0] f;
      for (int i = 0; i < n; i++) begin
         step();
         f = flags(which);
         chk("gap_valid", f[3], 0);
         for (int s = 0; s < 8; s++) chk($sformatf("gap_hold_s%0d", s), got_s(which, s), exp_out[s]);
      end
   endtask

   task automatic random_frame(input int which, input int kk, input bit gaps);
      for (int i = 0; i < kk; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle_cycles(which, int'($urandom_range(1, 3)));
         do_branch(which, rnd_bm(which == 0 ? 16 : 12), rnd_bm(which == 0 ? 16 : 12), i == kk - 1);
      end
   endtask

   initial begin
      logic [3:0] f;
      rst = 1'b1;
      a_blklen = '0; a_vblk = 1'b0; a_vbr = 1'b0; a_b1 = '0; a_b2 = '0;
      b_blklen = '0; b_vblk = 1'b0; b_vbr = 1'b0; b_b1 = '0; b_b2 = '0;
      step(); step();
      for (int s = 0; s < 8; s++) chk($sformatf("rst_alpha_s%0d", s), got_s(0, s), 0);
      f = flags(0);
      chk("rst_valid", f[3], 0); chk("rst_last", f[2], 0);
      chk("rst_busy", f[1], 0);  chk("rst_err", f[0], 0);
      rst = 1'b0;
      step();

      // Zero branches
      ref_init(16);
      send_len(0, 40);
      chk("zero_busy_rise", a_busy, 1);
      chk("zero_accept_err", a_err, 0);
      for (int i = 0; i < 40; i++) begin
         do_branch(0, 0, 0, i == 39);
         if (i == 0) begin
            chk("zero_step0_s0", got_s(0, 0), 0);
            chk("zero_step0_s7", got_s(0, 7), -16384);
         end
         if (i == 1) begin
            chk("zero_step1_s0", got_s(0, 0), 0);
            chk("zero_step1_s4", got_s(0, 4), 0);
            chk("zero_step1_s1", got_s(0, 1), -16384);
         end
      end
      idle_cycles(0, 2);
      chk("zero_busy_after", a_busy, 0);

      // Single step
      ref_init(16);
      send_len(0, 40);
      do_branch(0, 10, 4, 1'b0);
      do_branch(0, rnd_bm(16), rnd_bm(16), 1'b0);
      chk("single_s0", got_s(0, 0), 0);
      chk("single_s4", got_s(0, 4), 20);
      for (int s = 1; s < 8; s++)
         if (s != 4) chk($sformatf("single_low_s%0d", s), longint'(got_s(0, s) <= -16000), 1);
      for (int i = 2; i < 40; i++) do_branch(0, rnd_bm(16), rnd_bm(16), i == 39);

      // Length and idle-branch errors
      send_len(0, 39);
      f = flags(0);
      chk("len39_err", f[0], 1); chk("len39_busy", f[1], 0); chk("len39_valid", f[3], 0);
      step();
      chk("len39_err_clear", a_err, 0);
      send_len(0, 6145);
      f = flags(0);
      chk("len6145_err", f[0], 1); chk("len6145_busy", f[1], 0); chk("len6145_valid", f[3], 0);
      a_vbr = 1'b1;
      step();
      a_vbr = 1'b0;
      chk("idle_branch_err", a_err, 1);
      chk("idle_branch_valid", a_valid, 0);
      chk("idle_branch_busy", a_busy, 0);

      // Length and branch together in IDLE: length wins, branch dropped
      ref_init(16);
      a_blklen = 16'd40; a_vblk = 1'b1; a_vbr = 1'b1; a_b1 = 16'sd500; a_b2 = -16'sd300;
      step();
      a_vblk = 1'b0; a_vbr = 1'b0;
      chk("both_err", a_err, 1); chk("both_busy", a_busy, 1); chk("both_valid", a_valid, 0);

      // Frame 1 with stalls and a stray mid-frame length, then back-to-back frame 2
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            a_blklen = 16'd100; a_vblk = 1'b1;
            step();
            a_vblk = 1'b0;
            chk("mid_len_err", a_err, 1); chk("mid_len_busy", a_busy, 1); chk("mid_len_valid", a_valid, 0);
         end
         if ($urandom_range(0, 3) == 0) idle_cycles(0, int'($urandom_range(1, 3)));
         do_branch(0, rnd_bm(16), rnd_bm(16), i == 39);
      end
      ref_init(16);
      send_len(0, 40);
      chk("b2b_busy", a_busy, 1);
      chk("b2b_err", a_err, 0);
      random_frame(0, 40, 1'b1);

      // Saturation on the 12-bit instance, then a random 12-bit frame
      ref_init(12);
      send_len(1, 64);
      for (int i = 0; i < 64; i++) begin
         do_branch(1, 1000, 1000, i == 63);
         for (int s = 0; s < 8; s++)
            chk($sformatf("sat_range_s%0d", s),
                longint'(got_s(1, s) >= -2048 && got_s(1, s) <= 2047), 1);
         chk("sat_s0_zero", got_s(1, 0), 0);
      end
      ref_init(12);
      send_len(1, 40);
      random_frame(1, 40, 1'b1);

      // Reset mid-frame
      ref_init(16);
      send_len(0, 40);
      for (int i = 0; i < 17; i++) do_branch(0, rnd_bm(16), rnd_bm(16), 1'b0);
      rst = 1'b1;
      #1;
      for (int s = 0; s < 8; s++) chk($sformatf("arst_alpha_s%0d", s), got_s(0, s), 0);
      f = flags(0);
      chk("arst_valid", f[3], 0); chk("arst_last", f[2], 0);
      chk("arst_busy", f[1], 0);  chk("arst_err", f[0], 0);
      step(); step();
      rst = 1'b0;
      step();
      chk("post_rst_valid", a_valid, 0);
      chk("post_rst_busy", a_busy, 0);
      ref_init(16);
      send_len(0, 40);
      random_frame(0, 40, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
